spi_helpers_minion_arbiter: RTL
===============================

// Module: spi_helpers_Minion_Arbiter
// PURPOSE
//  Shares one SPI minion adapter among NUM_REQS on-chip requesters.
//  Upstream: round-robin arbitration of requester val/rdy channels onto the adapter recv port; grant ID is prepended in the MSBs.
//  Downstream: adapter send-port messages are routed to the requester named by their ID field.
//  Sits between the adapter's recv/send val/rdy ports and the client blocks.
// PARAMETERS
//  nbits     8   SPI frame width; adapter payload is AW = nbits-2
//  NUM_REQS  4   number of requesters, 2..2**(AW-1)
//  Derived: IDW = $clog2(NUM_REQS); PW = AW-IDW (requester payload width).
// PORTS
//  clk            in   1            clock
//  reset          in   1            asynchronous, active-low reset
//  req_val        in   NUM_REQS     requester i has a message
//  req_rdy        out  NUM_REQS     requester i message accepted this cycle
//  req_msg        in   NUM_REQS*PW  requester payloads, slice i = [i*PW +: PW]
//  resp_val       out  NUM_REQS     response valid for requester i
//  resp_rdy       in   NUM_REQS     requester i accepts response
//  resp_msg       out  PW           response payload, shared by all requesters
//  adp_recv_val   out  1            to adapter recv_val
//  adp_recv_rdy   in   1            from adapter recv_rdy
//  adp_recv_msg   out  AW           {id, payload} to adapter recv_msg
//  adp_send_val   in   1            from adapter send_val
//  adp_send_rdy   out  1            to adapter send_rdy
//  adp_send_msg   in   AW           {id, payload} from adapter send_msg
//  err_count      out  8            dropped-message counter; only with SPI_ARB_ERRCNT_EN
// BEHAVIOUR
//  - Reset (reset=0, async): RR pointer=0; both output registers empty.
//    adp_recv_val=0, resp_val=0, req_rdy=0, adp_send_rdy=0, err_count=0.
//  - Up register (1 entry):
//    - load_up = !up_full | adp_recv_rdy.
//    - Winner = first i with req_val[i], searching from ptr upward and wrapping.
//    - If load_up and a winner exists: req_rdy[winner]=1 (one-hot), and the register loads {winner[IDW-1:0], req_msg[winner]}.
//    - Otherwise req_rdy=0.
//    - Latency: req accept -> adp_recv_val is 1 cycle.
//    - Full throughput: 1 msg/cycle while adp_recv_rdy=1.
//  - RR pointer: on a grant, ptr <= (winner==NUM_REQS-1) ? 0 : winner+1.
//    No grant: ptr unchanged.
//  - Up register drain: adp_recv_val=up_full.
//    - Fire with no reload: empties.
//    - Fire and reload in the same cycle: holds the new msg, no bubble.
//  - Down register (1 entry) holds {id, payload} taken from adp_send_msg.
//    - id = adp_send_msg[AW-1 -: IDW].
//    - adp_send_rdy = !dn_full | dn_fire.
//    - resp_val[i] = dn_full & (dn_id==i).
//    - dn_fire = |(resp_val & resp_rdy).
//    - resp_msg = dn_payload.
//    - Latency: adapter send -> resp_val is 1 cycle.
//  - Invalid ID (id >= NUM_REQS, non-power-of-2 NUM_REQS only):
//    - Accepted (adp_send_rdy per the rule above) but never loaded into the down register, i.e. dropped.
//    - One error event.
//  - Backpressure: a stalled requester holds the down register.
//    - Other requesters' responses wait behind it (in-order, no bypass).
//  - Simultaneous fire and load on the down register: same as up (no bubble).
//  - Requester dropping req_val without req_rdy: allowed, no state change.
//  - Reset mid-transfer: in-flight register contents are discarded, not delivered.
// CONFIGURATION
//  SPI_ARB_ERRCNT_EN defined:
//    - err_count port exists.
//    - Increments on each invalid-ID drop; saturates at 8'hFF.
//    - Resets to 0.
//  Undefined:
//    - No err_count port and no counter logic.
//    - Invalid-ID messages are dropped silently.
// STRUCTURE
//  Package spi_helpers_arb_pkg:
//    - function id_width(n) returning $clog2(n).
//    - Parameterised typedef of the {id, payload} struct.
//    - localparam ERRCNT_W = 8.
//  Sub-module spi_helpers_RR_Arbiter #(N):
//    - Inputs: req[N], en.
//    - Outputs: grant one-hot, grant_id.
//    - Owns the rotating pointer; advances only when en & |req.
//  Top level: two 1-entry pipe registers, ID decode, optional counter.
// TESTING
//  (nbits=8, NUM_REQS=4: AW=6, IDW=2, PW=4)
//  1. Single requester: req_val=4'b0100, req_msg[2]=4'hA, adp_recv_rdy=1 -> req_rdy=4'b0100; next cycle adp_recv_val=1, adp_recv_msg=6'b10_1010.
//  2. Fairness: all req_val=1 for 8 cycles, adp_recv_rdy=1 -> grants 0,1,2,3,0,1,2,3; adp_recv_val high every cycle after the first.
//  3. Up stall: adp_recv_rdy=0 for 3 cycles with req_val=4'b0011 -> one message held, req_rdy=0 while full, ptr frozen; on release, req1 is granted next.
//  4. Routing: adp_send_msg=6'b01_0110 with adp_send_val=1 and resp_rdy=4'b1111 -> next cycle resp_val=4'b0010, resp_msg=4'h6; back-to-back sends give no bubble.
//  5. Down backpressure: resp_rdy[3]=0 with a msg for id 3, then a msg for id 0 -> adp_send_rdy=0 until resp_rdy[3]=1; delivery order is 3 then 0.
//  6. NUM_REQS=3, SPI_ARB_ERRCNT_EN: send id 2'b11 -> accepted, no resp_val, err_count 0->1; async reset mid-stream -> all val outputs 0 immediately.

Source files
------------

// File: rtl/spi_helpers_minion_arbiter_pkg.sv
// Shared types and helpers for the SPI minion arbiter.
// Optional feature macro used by the top level: SPI_ARB_ERRCNT_EN.
package spi_helpers_arb_pkg;

  // Width of the dropped-message counter.
  localparam int ERRCNT_W = 8;

  // Default frame configuration: 8-bit SPI frame, 4 requesters.
  localparam int DEF_NBITS    = 8;
  localparam int DEF_NUM_REQS = 4;

  // Number of ID bits needed to name one of n requesters. A single
  // requester still gets one bit so that vectors never collapse to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_AW  = DEF_NBITS - 2;
  localparam int DEF_IDW = id_width(DEF_NUM_REQS);
  localparam int DEF_PW  = DEF_AW - DEF_IDW;

  // {id, payload} as carried on the adapter ports. The top level
  // re-declares this shape with its own IDW/PW parameters.
  typedef struct packed {
    logic [DEF_IDW-1:0] id;
    logic [DEF_PW-1:0]  payload;
  } arb_msg_t;

endpackage

// File: rtl/spi_helpers_minion_arbiter_rr.sv
// Round-robin arbiter with a rotating priority pointer.
// The pointer names the requester with highest priority; after a grant it
// moves to the slot just past the winner, so every requester is served in turn.
module spi_helpers_rr_arbiter
  import spi_helpers_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_win;
  logic           w_found;
  int             v_idx;

  // Find the first requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int k = 0; k < N; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= N) v_idx = v_idx - N;
      if (!w_found && req[IDW'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(v_idx);
      end
    end
  end

  assign grant    = (en && w_found) ? (N'(1) << w_win) : '0;
  assign grant_id = w_win;

  // Advance the pointer past the winner only when a grant is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/spi_helpers_minion_arbiter.sv
// Shares one SPI minion adapter among NUM_REQS requesters.
// Upstream: round-robin arbitration into a 1-entry register feeding the
// adapter recv port, with the grant ID prepended in the MSBs.
// Downstream: a 1-entry register routes adapter send messages to the
// requester named by their ID field; IDs beyond NUM_REQS are dropped.
// Optional macro SPI_ARB_ERRCNT_EN adds a saturating err_count output.
//
// Handshake rule for every val/rdy pair here: a transfer happens in a cycle
// exactly when val and rdy are both high at the rising clock edge; val never
// depends on rdy, and the sender may withdraw val when no transfer happened.
module spi_helpers_minion_arbiter
  import spi_helpers_arb_pkg::*;
#(
  parameter int nbits    = 8,
  parameter int NUM_REQS = 4,
  localparam int AW  = nbits - 2,
  localparam int IDW = id_width(NUM_REQS),
  localparam int PW  = AW - IDW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQS-1:0]    req_val,
  output logic [NUM_REQS-1:0]    req_rdy,
  input  logic [NUM_REQS*PW-1:0] req_msg,
  output logic [NUM_REQS-1:0]    resp_val,
  input  logic [NUM_REQS-1:0]    resp_rdy,
  output logic [PW-1:0]          resp_msg,
  output logic                   adp_recv_val,
  input  logic                   adp_recv_rdy,
  output logic [AW-1:0]          adp_recv_msg,
  input  logic                   adp_send_val,
  output logic                   adp_send_rdy,
  input  logic [AW-1:0]          adp_send_msg
`ifdef SPI_ARB_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]    err_count
`endif
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PW-1:0]  payload;
  } msg_t;

  localparam logic [IDW:0] NREQ_L = (IDW + 1)'(NUM_REQS);

  // Held low during reset and for the first clock after it, so that no
  // ready is offered while the block is still coming out of reset.
  logic r_active;

  // Up path
  logic           r_up_full;
  msg_t           r_up_q;
  logic           w_load_up;
  logic [NUM_REQS-1:0] w_grant;
  logic [IDW-1:0] w_grant_id;
  logic [PW-1:0]  w_req_payload;

  // Down path
  logic           r_dn_full;
  msg_t           r_dn_q;
  logic           w_dn_fire;
  logic           w_send_fire;
  logic [IDW-1:0] w_send_id;
  logic           w_id_ok;

  // Track when the block is live after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_active <= 1'b0;
    else        r_active <= 1'b1;
  end

  // ---------------- Up path ----------------
  assign w_load_up = r_active && (!r_up_full || adp_recv_rdy);

  spi_helpers_rr_arbiter #(
    .N   (NUM_REQS),
    .IDW (IDW)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (req_val),
    .en       (w_load_up),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  assign req_rdy = w_grant;

  // Select the winning requester's payload slice.
  always_comb begin
    w_req_payload = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_grant[i]) w_req_payload = req_msg[i*PW +: PW];
    end
  end

  // Up register: load on a grant (also covers drain-and-reload), else drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up_full <= 1'b0;
      r_up_q    <= '0;
    end else if (|w_grant) begin
      r_up_full <= 1'b1;
      r_up_q    <= '{id: w_grant_id, payload: w_req_payload};
    end else if (adp_recv_rdy) begin
      r_up_full <= 1'b0;
    end
  end

  assign adp_recv_val = r_up_full;
  assign adp_recv_msg = r_up_q;

  // ---------------- Down path ----------------
  // Route the held response to the requester named by its ID.
  always_comb begin
    resp_val = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      resp_val[i] = r_dn_full && (r_dn_q.id == IDW'(i));
    end
  end

  assign resp_msg     = r_dn_q.payload;
  assign w_dn_fire    = |(resp_val & resp_rdy);
  assign adp_send_rdy = r_active && (!r_dn_full || w_dn_fire);
  assign w_send_fire  = adp_send_val && adp_send_rdy;
  assign w_send_id    = adp_send_msg[AW-1 -: IDW];
  assign w_id_ok      = ({1'b0, w_send_id} < NREQ_L);

  // Down register: accepted valid-ID messages load; a lone delivery empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dn_full <= 1'b0;
      r_dn_q    <= '0;
    end else if (w_send_fire && w_id_ok) begin
      r_dn_full <= 1'b1;
      r_dn_q    <= adp_send_msg;
    end else if (w_dn_fire) begin
      r_dn_full <= 1'b0;
    end
  end

`ifdef SPI_ARB_ERRCNT_EN
  logic                r_drop_unused;
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic                w_drop;

  assign w_drop = w_send_fire && !w_id_ok;

  // Count invalid-ID drops, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt     <= '0;
      r_drop_unused <= 1'b0;
    end else begin
      r_drop_unused <= 1'b0;
      if (w_drop && (r_err_cnt != {ERRCNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt | {ERRCNT_W{r_drop_unused}};
`endif

endmodule
